// File: rtl/ram_dma_engine.sv
// Block copy/fill engine for the GPU ports of Unified_MultiPort_RAM.
// Reads through port 0 (combinational q) and writes through port 1 using a two-stage read/write pipeline.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; command fields are latched on accept
// RUN   | read stage steps r, write stage retires the captured word
// DRAIN | all reads issued; the last captured word is written
// DONE  | one-cycle done pulse, then back to IDLE
module ram_dma_engine #(
  parameter int unsigned MEM_LEN = 20480,
  parameter int          LEN_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_value,
  input  logic             hold,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      rd_q,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_d
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_RANGE = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;

  state_t state, state_nxt;

  logic             mode_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      fill_q;
  logic [LEN_W-1:0] rd_idx;
  logic [LEN_W-1:0] wr_idx;
  logic [31:0]      data_q;
  logic             data_vld;
  logic [1:0]       status_q;

  logic [32:0] dst_end;
  logic [32:0] src_end;
  logic        range_err;
  logic        accept;
  logic        active;
  logic        advance;
  logic        last_rd;

  // End addresses are formed one bit wider so a huge base cannot wrap into range.
  assign dst_end   = {1'b0, dst_addr} + 33'(len);
  assign src_end   = {1'b0, src_addr} + 33'(len);
  assign range_err = (dst_end > 33'(MEM_LEN)) || (!mode && (src_end > 33'(MEM_LEN)));

  assign accept  = (state == S_IDLE) && start;
  assign active  = (state == S_RUN) || (state == S_DRAIN);
  assign advance = active && !hold && !abort;
  assign last_rd = (rd_idx == (len_q - LEN_W'(1)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (range_err || (len == '0)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        wr_en = data_vld && !hold && !abort;
        if (abort) begin
          state_nxt = S_DONE;
        end else if (!hold && last_rd) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy  = 1'b1;
        wr_en = data_vld && !hold && !abort;
        if (abort || !hold) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      fill_q   <= '0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      data_q   <= '0;
      data_vld <= 1'b0;
      status_q <= ST_OK;
    end else begin
      if (accept) begin
        mode_q   <= mode;
        src_q    <= src_addr;
        dst_q    <= dst_addr;
        len_q    <= len;
        fill_q   <= fill_value;
        rd_idx   <= '0;
        data_vld <= 1'b0;
        status_q <= range_err ? ST_RANGE : ST_OK;
      end
      if (active && abort) begin
        status_q <= ST_ABORT;
      end
      // Fill mode still walks rd_addr so both modes share one timeline.
      if ((state == S_RUN) && advance) begin
        data_q   <= mode_q ? fill_q : rd_q;
        wr_idx   <= rd_idx;
        data_vld <= 1'b1;
        rd_idx   <= rd_idx + LEN_W'(1);
      end
      if (state_nxt == S_DONE) begin
        data_vld <= 1'b0;
      end
    end
  end

  assign status  = status_q;
  assign rd_addr = src_q + 32'(rd_idx);
  assign wr_addr = dst_q + 32'(wr_idx);
  assign wr_d    = data_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Directed bench for ram_dma_engine with a behavioural RAM behind the GPU ports.
// Cycle numbers count from the IDLE cycle in which start is driven.
module tb_ram_dma_engine;

  localparam int unsigned MEM_LEN = 20480;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic [31:0] fill_value;
  logic        hold;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [31:0] rd_addr;
  logic [31:0] rd_q;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_d;

  ram_dma_engine #(.MEM_LEN(MEM_LEN), .LEN_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
    .hold(hold), .abort(abort), .busy(busy), .done(done), .status(status),
    .rd_addr(rd_addr), .rd_q(rd_q), .wr_en(wr_en), .wr_addr(wr_addr), .wr_d(wr_d)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:32767];
  logic        pl_en;
  logic [31:0] pl_addr;
  logic [31:0] pl_data;
  int          wr_total;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr[14:0]] <= pl_data;
    else if (wr_en && (wr_addr < MEM_LEN)) mem[wr_addr[14:0]] <= wr_d;
  end

  always @(posedge clock) if (wr_en) wr_total = wr_total + 1;

  always_comb begin
    rd_q = 32'h0;
    if (rd_addr < MEM_LEN) rd_q = mem[rd_addr[14:0]];
  end

  int tests_run;
  int tests_failed;

  int          wr_cyc[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_dv[$];
  int          done_cyc;
  logic [1:0]  done_status;
  logic [63:0] busy_mask;

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clock); #1;
    pl_en = 1'b0;
  endtask

  // Drives one command starting in the current cycle and records what the DUT does.
  task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input logic [31:0] fv,
                          input logic [31:0] hmask, input int acyc);
    wr_cyc.delete(); wr_a.delete(); wr_dv.delete();
    done_cyc = -1; done_status = 2'b11; busy_mask = '0;
    mode = m; src_addr = s; dst_addr = d; len = n; fill_value = fv;
    for (int c = 0; c < 40; c++) begin
      start = (c == 0);
      hold  = (c < 32) ? hmask[c] : 1'b0;
      abort = (c == acyc);
      @(negedge clock);
      if (wr_en) begin
        wr_cyc.push_back(c); wr_a.push_back(wr_addr); wr_dv.push_back(wr_d);
      end
      if (busy) busy_mask[c] = 1'b1;
      if (done && done_cyc < 0) begin
        done_cyc = c; done_status = status;
      end
      @(posedge clock); #1;
      if (done_cyc >= 0) break;
    end
    start = 1'b0; hold = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({busy, done, wr_en, status} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy/done/wr_en/status=%b required 00000", {busy, done, wr_en, status});
    end
    tests_run++;
    if ({rd_addr, wr_addr, wr_d} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_addr: rd_addr=%h wr_addr=%h wr_d=%h required all 0", rd_addr, wr_addr, wr_d);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_copy;
    for (int k = 0; k < 8; k++) preload(32'd2048 + 32'(k), 32'(10 * (k + 1)));
    run_xfer(1'b0, 32'd2048, 32'd6144, 16'd4, 32'h0, 32'h0, -1);
    tests_run++;
    if (wr_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL copy_count: %0d writes required 4", wr_cyc.size());
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= wr_cyc.size() || wr_cyc[k] != k + 2 || wr_a[k] !== 32'd6144 + 32'(k) ||
          wr_dv[k] !== 32'(10 * (k + 1))) begin
        tests_failed++;
        $display("FAIL copy_word%0d: write not seen as cycle %0d addr %0d data %0d", k, k + 2, 6144 + k, 10 * (k + 1));
      end
    end
    tests_run++;
    if (done_cyc != 6 || done_status !== 2'b00) begin
      tests_failed++;
      $display("FAIL copy_done: cycle %0d status %b required cycle 6 status 00", done_cyc, done_status);
    end
    tests_run++;
    if (busy_mask !== 64'h3E) begin
      tests_failed++;
      $display("FAIL copy_busy: busy cycles %h required 3e", busy_mask);
    end
    tests_run++;
    if (mem[6147] !== 32'd40) begin
      tests_failed++;
      $display("FAIL copy_mem: mem[6147]=%0d required 40", mem[6147]);
    end
  endtask

  task automatic test_fill;
    run_xfer(1'b1, 32'd2048, 32'd4096, 16'd3, 32'hDEADBEEF, 32'h0, -1);
    tests_run++;
    if (wr_cyc.size() != 3) begin
      tests_failed++;
      $display("FAIL fill_count: %0d writes required 3", wr_cyc.size());
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= wr_cyc.size() || wr_cyc[k] != k + 2 || wr_a[k] !== 32'd4096 + 32'(k) ||
          wr_dv[k] !== 32'hDEADBEEF) begin
        tests_failed++;
        $display("FAIL fill_word%0d: write not seen as cycle %0d addr %0d data deadbeef", k, k + 2, 4096 + k);
      end
    end
    tests_run++;
    if (done_cyc != 5 || done_status !== 2'b00) begin
      tests_failed++;
      $display("FAIL fill_done: cycle %0d status %b required cycle 5 status 00", done_cyc, done_status);
    end
  endtask

  task automatic test_hold;
    int exp_c[4];
    exp_c = '{2, 5, 6, 7};
    run_xfer(1'b0, 32'd2048, 32'd8192, 16'd4, 32'h0, 32'h18, -1);
    tests_run++;
    if (wr_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL hold_count: %0d writes required 4", wr_cyc.size());
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (k >= wr_cyc.size() || wr_cyc[k] != exp_c[k] || wr_a[k] !== 32'd8192 + 32'(k) ||
          wr_dv[k] !== 32'(10 * (k + 1))) begin
        tests_failed++;
        $display("FAIL hold_word%0d: write not seen as cycle %0d addr %0d data %0d", k, exp_c[k], 8192 + k, 10 * (k + 1));
      end
    end
    tests_run++;
    if (done_cyc != 8) begin
      tests_failed++;
      $display("FAIL hold_done: cycle %0d required 8", done_cyc);
    end
  endtask

  task automatic test_range;
    run_xfer(1'b0, 32'd0, 32'd20478, 16'd4, 32'h0, 32'h0, -1);
    tests_run++;
    if (done_cyc != 1 || done_status !== 2'b01 || wr_cyc.size() != 0 || busy_mask !== '0) begin
      tests_failed++;
      $display("FAIL range_dst: done %0d status %b writes %0d busy %h required 1 01 0 0", done_cyc, done_status, wr_cyc.size(), busy_mask);
    end
    run_xfer(1'b0, 32'd20478, 32'd0, 16'd4, 32'h0, 32'h0, -1);
    tests_run++;
    if (done_cyc != 1 || done_status !== 2'b01 || wr_cyc.size() != 0) begin
      tests_failed++;
      $display("FAIL range_src: done %0d status %b writes %0d required 1 01 0", done_cyc, done_status, wr_cyc.size());
    end
    run_xfer(1'b1, 32'd20478, 32'd20476, 16'd4, 32'h5A5A5A5A, 32'h0, -1);
    tests_run++;
    if (done_cyc != 6 || done_status !== 2'b00 || wr_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL range_edge: done %0d status %b writes %0d required 6 00 4", done_cyc, done_status, wr_cyc.size());
    end
    tests_run++;
    if (wr_cyc.size() != 4 || wr_a[3] !== 32'd20479) begin
      tests_failed++;
      $display("FAIL range_edge_last: last write address not 20479 (writes %0d)", wr_cyc.size());
    end
    run_xfer(1'b0, 32'd0, 32'd0, 16'd0, 32'h0, 32'h0, -1);
    tests_run++;
    if (done_cyc != 1 || done_status !== 2'b00 || wr_cyc.size() != 0 || busy_mask !== '0) begin
      tests_failed++;
      $display("FAIL len_zero: done %0d status %b writes %0d busy %h required 1 00 0 0", done_cyc, done_status, wr_cyc.size(), busy_mask);
    end
  endtask

  task automatic test_abort;
    run_xfer(1'b0, 32'd2048, 32'd10000, 16'd8, 32'h0, 32'h0, 3);
    tests_run++;
    if (wr_cyc.size() != 1 || wr_cyc[0] != 2 || wr_a[0] !== 32'd10000 || wr_dv[0] !== 32'd10) begin
      tests_failed++;
      $display("FAIL abort_writes: %0d writes required one (cycle 2, addr 10000, data 10)", wr_cyc.size());
    end
    tests_run++;
    if (done_cyc != 4 || done_status !== 2'b10) begin
      tests_failed++;
      $display("FAIL abort_done: cycle %0d status %b required cycle 4 status 10", done_cyc, done_status);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    preload(32'd14001, 32'h55);
    base = wr_total;
    mode = 1'b0; src_addr = 32'd2048; dst_addr = 32'd14000; len = 16'd8; fill_value = 32'h0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, wr_en, status} !== 5'b0 || {rd_addr, wr_addr, wr_d} !== 96'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_out: busy %b done %b wr_en %b status %b rd %h wa %h wd %h required all 0",
               busy, done, wr_en, status, rd_addr, wr_addr, wr_d);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (wr_total - base != 1 || mem[14001] !== 32'h55) begin
      tests_failed++;
      $display("FAIL mid_reset_writes: %0d writes mem[14001]=%h required 1 and 55", wr_total - base, mem[14001]);
    end
    run_xfer(1'b0, 32'd2048, 32'd12000, 16'd2, 32'h0, 32'h0, -1);
    tests_run++;
    if (done_cyc != 4 || done_status !== 2'b00 || wr_cyc.size() != 2 || wr_dv[1] !== 32'd20) begin
      tests_failed++;
      $display("FAIL mid_reset_restart: done %0d status %b writes %0d required 4 00 2", done_cyc, done_status, wr_cyc.size());
    end
  endtask

  task automatic test_back_to_back;
    run_xfer(1'b1, 32'd0, 32'd15000, 16'd2, 32'h11111111, 32'h0, -1);
    run_xfer(1'b0, 32'd2048, 32'd15002, 16'd3, 32'h0, 32'h0, -1);
    tests_run++;
    if (done_cyc != 5 || wr_cyc.size() != 3 || wr_cyc[0] != 2 || wr_dv[2] !== 32'd30) begin
      tests_failed++;
      $display("FAIL b2b_second: done %0d writes %0d required done 5 with 3 writes from cycle 2", done_cyc, wr_cyc.size());
    end
    tests_run++;
    if (mem[15001] !== 32'h11111111 || mem[15002] !== 32'd10) begin
      tests_failed++;
      $display("FAIL b2b_mem: mem[15001]=%h mem[15002]=%h required 11111111 and 0000000a", mem[15001], mem[15002]);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; wr_total = 0;
    start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill_value = '0; hold = 1'b0; abort = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset;
    test_copy;
    test_fill;
    test_hold;
    test_range;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
